// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins, and mul/div results wait in a one-entry buffer.
// Optional macro WB_ARB_BYPASS_EN lets an accept into an empty buffer write straight through when the pipeline is idle.
module wb_port_arbiter #(
  parameter int Width     = 32,
  parameter int StarveMax = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [Width-1:0] wb_data,
  input  logic             md_valid,
  output logic             md_ready,
  input  logic [4:0]       md_rd,
  input  logic [Width-1:0] md_data,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [Width-1:0] rf_wd,
  output logic             stall_req
);

  typedef enum logic [1:0] {IDLE, PEND, STALL} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(StarveMax);

  state_t           state_reg, state_next;
  logic             buf_valid_reg, buf_valid_next;
  logic [4:0]       buf_rd_reg, buf_rd_next;
  logic [Width-1:0] buf_data_reg, buf_data_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             rf_we_next;
  logic [4:0]       rf_rd_next;
  logic [Width-1:0] rf_wd_next;
  logic             stall_next;

  logic wb_eff, md_accept, md_keep, supersede, bypass;

  assign md_ready  = !buf_valid_reg;
  assign wb_eff    = wb_we && (wb_rd != 5'd0);
  assign md_accept = md_valid && md_ready;
  // A result for r0, or one overwritten by a same-cycle pipeline write, is accepted and dropped.
  assign md_keep   = md_accept && (md_rd != 5'd0) && !(wb_eff && (wb_rd == md_rd));
  assign supersede = buf_valid_reg && wb_eff && (wb_rd == buf_rd_reg);

`ifdef WB_ARB_BYPASS_EN
  assign bypass = md_keep && !wb_eff;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    buf_valid_next = buf_valid_reg;
    buf_rd_next    = buf_rd_reg;
    buf_data_next  = buf_data_reg;
    cnt_next       = cnt_reg;
    rf_we_next     = 1'b0;
    rf_rd_next     = rf_rd;
    rf_wd_next     = rf_wd;

    if (wb_eff) begin
      rf_we_next = 1'b1;
      rf_rd_next = wb_rd;
      rf_wd_next = wb_data;
    end

    case (state_reg)
      IDLE: begin
        if (bypass) begin
          rf_we_next = 1'b1;
          rf_rd_next = md_rd;
          rf_wd_next = md_data;
        end else if (md_keep) begin
          buf_valid_next = 1'b1;
          buf_rd_next    = md_rd;
          buf_data_next  = md_data;
          cnt_next       = 4'd0;
          state_next     = PEND;
        end
      end
      PEND, STALL: begin
        if (supersede) begin
          buf_valid_next = 1'b0;
          cnt_next       = 4'd0;
          state_next     = IDLE;
        end else if (!wb_eff) begin
          rf_we_next     = 1'b1;
          rf_rd_next     = buf_rd_reg;
          rf_wd_next     = buf_data_reg;
          buf_valid_next = 1'b0;
          cnt_next       = 4'd0;
          state_next     = IDLE;
        end else if (state_reg == PEND) begin
          // Denied again; the StarveMax-th denial escalates to a bubble request.
          cnt_next = cnt_reg + 4'd1;
          if (cnt_next == STARVE_MAX) state_next = STALL;
        end
      end
      default: begin
        buf_valid_next = 1'b0;
        cnt_next       = 4'd0;
        state_next     = IDLE;
      end
    endcase

    stall_next = (state_next == STALL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      buf_valid_reg <= 1'b0;
      buf_rd_reg    <= 5'd0;
      buf_data_reg  <= '0;
      cnt_reg       <= 4'd0;
      rf_we         <= 1'b0;
      rf_rd         <= 5'd0;
      rf_wd         <= '0;
      stall_req     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      buf_valid_reg <= buf_valid_next;
      buf_rd_reg    <= buf_rd_next;
      buf_data_reg  <= buf_data_next;
      cnt_reg       <= cnt_next;
      rf_we         <= rf_we_next;
      rf_rd         <= rf_rd_next;
      rf_wd         <= rf_wd_next;
      stall_req     <= stall_next;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed steps and then random traffic, all checked against a pending-result model.
module tb_wb_port_arbiter;
  localparam int W      = 32;
  localparam int STARVE = 4;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_we, md_valid, md_ready, rf_we, stall_req;
  logic [4:0]   wb_rd, md_rd, rf_rd;
  logic [W-1:0] wb_data, md_data, rf_wd;

  int errors = 0;
  int checks = 0;

  // The model keeps at most one pending result and counts the cycles it has lost to the pipeline.
  bit           q_valid;
  logic [4:0]   q_rd;
  logic [W-1:0] q_data;
  int           denied;
  bit           exp_we;
  logic [4:0]   exp_rd;
  logic [W-1:0] exp_wd;

  wb_port_arbiter #(.Width(W), .StarveMax(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_valid = 1'b0;
    q_rd    = '0;
    q_data  = '0;
    denied  = 0;
    exp_we  = 1'b0;
  endtask

  // Predict the effect of the upcoming edge, advance one clock, then compare at the falling edge.
  task automatic cycle(input string tag);
    bit eff, acc, had;
    eff    = wb_we && (wb_rd != 5'd0);
    acc    = md_valid && !q_valid;
    had    = q_valid;
    exp_we = 1'b0;
    if (eff) begin
      exp_we = 1'b1;
      exp_rd = wb_rd;
      exp_wd = wb_data;
      if (had && q_rd == wb_rd) begin
        q_valid = 1'b0;
        had     = 1'b0;
        denied  = 0;
      end
    end
    if (had) begin
      if (!eff) begin
        exp_we  = 1'b1;
        exp_rd  = q_rd;
        exp_wd  = q_data;
        q_valid = 1'b0;
        denied  = 0;
      end else begin
        denied++;
      end
    end else if (acc && md_rd != 5'd0 && !(eff && md_rd == wb_rd)) begin
      if (BYPASS && !eff) begin
        exp_we = 1'b1;
        exp_rd = md_rd;
        exp_wd = md_data;
      end else begin
        q_valid = 1'b1;
        q_rd    = md_rd;
        q_data  = md_data;
        denied  = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, ".rf_we"}, 32'(rf_we), 32'(exp_we));
    check({tag, ".stall_req"}, 32'(stall_req), 32'(q_valid && denied >= STARVE));
    check({tag, ".md_ready"}, 32'(md_ready), 32'(!q_valid));
    if (exp_we) begin
      check({tag, ".rf_rd"}, 32'(rf_rd), 32'(exp_rd));
      check({tag, ".rf_wd"}, 32'(rf_wd), 32'(exp_wd));
    end
    $display("cyc %-10s wb=%0d/%0d md=%0d/%0d -> rf_we=%0d rf_rd=%0d rf_wd=%0h stall=%0d rdy=%0d",
             tag, wb_we, wb_rd, md_valid, md_rd, rf_we, rf_rd, rf_wd, stall_req, md_ready);
  endtask

  task automatic drive(input bit we, input int rd, input int wd, input bit mv, input int mr, input int md);
    wb_we    = we;
    wb_rd    = 5'(rd);
    wb_data  = W'(wd);
    md_valid = mv;
    md_rd    = 5'(mr);
    md_data  = W'(md);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst.rf_we", 32'(rf_we), 0);
    check("rst.rf_rd", 32'(rf_rd), 0);
    check("rst.rf_wd", rf_wd, 0);
    check("rst.stall_req", 32'(stall_req), 0);
    check("rst.md_ready", 32'(md_ready), 1);
    rst_n = 1'b1;

    // Pipeline write appears one cycle later.
    drive(1, 5, 32'h1234, 0, 0, 0);
    cycle("wb5");
    check("wb5.rd_const", 32'(rf_rd), 5);
    check("wb5.wd_const", rf_wd, 32'h1234);
    drive(0, 0, 0, 0, 0, 0);
    cycle("idle");

    // Mul/div result with the pipeline idle.
    drive(0, 0, 0, 1, 8, 32'hAA);
    cycle("md8_acc");
    check("md8.first_we", 32'(rf_we), 32'(BYPASS));
    drive(0, 0, 0, 0, 0, 0);
    cycle("md8_wr");
    check("md8.second_we", 32'(rf_we), 32'(!BYPASS));
    cycle("idle");

    // Starvation: buffer rd=8 loses to rd=3 for StarveMax cycles, then drains.
    drive(1, 3, 32'h33, 1, 8, 32'h88);
    cycle("starve_acc");
    drive(1, 3, 32'h33, 0, 0, 0);
    for (int i = 0; i < STARVE; i++) cycle("starve");
    check("starve.stall_up", 32'(stall_req), 1);
    cycle("starve_hold");
    drive(0, 0, 0, 0, 0, 0);
    cycle("drain");
    check("drain.rd_const", 32'(rf_rd), 8);
    check("drain.stall_down", 32'(stall_req), 0);
    cycle("idle");

    // Supersede: buffered rd=9 is overwritten by a newer pipeline write to rd=9.
    drive(1, 3, 32'h33, 1, 9, 32'hBB);
    cycle("sup_acc");
    drive(1, 9, 32'hCC, 0, 0, 0);
    cycle("sup_wb");
    check("sup.wd_const", rf_wd, 32'hCC);
    drive(0, 0, 0, 0, 0, 0);
    cycle("sup_after");
    check("sup.no_bb", 32'(rf_we), 0);

    // Register 0 is never written from either source.
    drive(0, 0, 0, 1, 0, 32'h55);
    cycle("md_r0");
    drive(1, 0, 32'h66, 0, 0, 0);
    cycle("wb_r0");
    drive(0, 0, 0, 0, 0, 0);
    cycle("r0_after");

    // Reach STALL again, then pulse reset in the middle of a cycle.
    drive(1, 4, 32'h44, 1, 7, 32'h77);
    cycle("rst_acc");
    drive(1, 4, 32'h44, 0, 0, 0);
    for (int i = 0; i < STARVE; i++) cycle("rst_starve");
    #2 rst_n = 1'b0;
    #1;
    check("arst.rf_we", 32'(rf_we), 0);
    check("arst.rf_rd", 32'(rf_rd), 0);
    check("arst.rf_wd", rf_wd, 0);
    check("arst.stall_req", 32'(stall_req), 0);
    check("arst.md_ready", 32'(md_ready), 1);
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst");
    cycle("post_rst2");

    // Random traffic on a small register range so supersedes, r0 drops and stalls all occur.
    for (int i = 0; i < 1500; i++) begin
      int pct;
      pct = ((i / 100) % 2 == 1) ? 90 : 40;
      drive($urandom_range(0, 99) < pct, $urandom_range(0, 3), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
